// File: rtl/btn_debounce_pkg.sv
// Shared types and constants for the push-button conditioning block.
package btn_pkg;

  localparam int unsigned DB_CNT_W          = 24;
  localparam int unsigned HOLD_CNT_W        = 28;

  // 10 ms debounce and 0.5 s long-press at a 100 MHz clk
  localparam int unsigned DEF_STABLE_CYCLES = 1_000_000;
  localparam int unsigned DEF_HOLD_CYCLES   = 50_000_000;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } db_state_t;

endpackage

// File: rtl/btn_debounce_sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/btn_debounce.sv
// Button debouncer: synchronised level, stability FSM, rise/fall pulses and
// a once-per-press long-press pulse.
//
//   state       | meaning
//   STABLE_LOW  | out=0, waiting for the synchronised input to go high
//   WAIT_HIGH   | out=0, counting consecutive high samples
//   STABLE_HIGH | out=1, waiting for the synchronised input to go low
//   WAIT_LOW    | out=1, counting consecutive low samples
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic hold
);

  localparam logic [DB_CNT_W-1:0]   DB_LAST   = DB_CNT_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_CNT_W-1:0] HOLD_MAX  = HOLD_CNT_W'(HOLD_CYCLES);

  logic                  w_s;
  db_state_t             r_state;
  db_state_t             w_state_nxt;
  logic [DB_CNT_W-1:0]   r_db_cnt;
  logic [DB_CNT_W-1:0]   w_db_cnt_nxt;
  logic [HOLD_CNT_W-1:0] r_hold_cnt;
  logic                  w_accept_hi;
  logic                  w_accept_lo;
  logic                  r_out;
  logic                  r_rise;
  logic                  r_fall;
  logic                  r_hold;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in),
    .q     (w_s)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_db_cnt_nxt = r_db_cnt;
    w_accept_hi  = 1'b0;
    w_accept_lo  = 1'b0;
    unique case (r_state)
      STABLE_LOW: begin
        if (w_s) begin
          w_state_nxt  = WAIT_HIGH;
          w_db_cnt_nxt = '0;
        end
      end
      WAIT_HIGH: begin
        if (!w_s) begin
          w_state_nxt = STABLE_LOW;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt = STABLE_HIGH;
          w_accept_hi = 1'b1;
        end else begin
          w_db_cnt_nxt = r_db_cnt + 1'b1;
        end
      end
      STABLE_HIGH: begin
        if (!w_s) begin
          w_state_nxt  = WAIT_LOW;
          w_db_cnt_nxt = '0;
        end
      end
      WAIT_LOW: begin
        if (w_s) begin
          w_state_nxt = STABLE_HIGH;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt = STABLE_LOW;
          w_accept_lo = 1'b1;
        end else begin
          w_db_cnt_nxt = r_db_cnt + 1'b1;
        end
      end
      default: w_state_nxt = STABLE_LOW;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= STABLE_LOW;
      r_db_cnt   <= '0;
      r_hold_cnt <= '0;
      r_out      <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_hold     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_db_cnt <= w_db_cnt_nxt;
      r_rise   <= w_accept_hi;
      r_fall   <= w_accept_lo;
      r_hold   <= 1'b0;
      if (w_accept_hi) begin
        r_out <= 1'b1;
      end else if (w_accept_lo) begin
        r_out <= 1'b0;
      end
      // A release accepted on the hold boundary wins: no hold on the fall cycle
      if (w_accept_hi || w_accept_lo) begin
        r_hold_cnt <= '0;
      end else if (r_out && (r_hold_cnt != HOLD_MAX)) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
        r_hold     <= (r_hold_cnt == HOLD_LAST);
      end
    end
  end

  assign out  = r_out;
  assign rise = r_rise;
  assign fall = r_fall;
  assign hold = r_hold;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed and random button traffic, reference
// model feeding an expected-pulse queue, negedge monitor comparing.
module tb_btn_debounce;

  localparam int S = 4;
  localparam int H = 20;

  typedef struct {
    logic [2:0] vec;   // {rise, fall, hold}
    int         cyc;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic b_in = 1'b0;
  logic b_out, b_rise, b_fall, b_hold;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  ev_t q[$];

  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;
  logic m_out = 1'b0;
  int   m_run = 0;
  int   hold_due = -1;

  btn_debounce #(.STABLE_CYCLES(S), .HOLD_CYCLES(H)) dut (
    .clk   (clk),
    .reset (reset),
    .in    (b_in),
    .out   (b_out),
    .rise  (b_rise),
    .fall  (b_fall),
    .hold  (b_hold)
  );

  always #5 clk = ~clk;

  // Reference: a change is accepted once S+1 consecutive synchronised samples
  // disagree with the current level; hold is due H cycles after the rise.
  always @(posedge clk) begin
    logic s;
    ev_t  e;
    cyc = cyc + 1;
    if (reset) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_out = 1'b0; m_run = 0; hold_due = -1;
    end else begin
      s    = m_s2;
      m_s2 = m_s1;
      m_s1 = b_in;
      if (s != m_out) m_run = m_run + 1;
      else            m_run = 0;
      if (m_run == S + 1) begin
        m_run = 0;
        m_out = ~m_out;
        e.cyc = cyc;
        if (m_out) begin
          e.vec = 3'b100;
          hold_due = cyc + H;
        end else begin
          e.vec = 3'b010;
          hold_due = -1;
        end
        q.push_back(e);
      end else if (m_out && cyc == hold_due) begin
        e.vec = 3'b001;
        e.cyc = cyc;
        q.push_back(e);
        hold_due = -1;
      end
    end
  end

  initial begin
    logic [2:0] pv;
    ev_t e;
    forever begin
      @(negedge clk);
      n_cmp++;
      if (b_out !== (reset ? 1'b0 : m_out)) begin
        n_err++;
        $display("FAIL out_level cyc=%0d got=%b required=%b", cyc, b_out, reset ? 1'b0 : m_out);
      end
      pv = {b_rise, b_fall, b_hold};
      if (reset) begin
        while (q.size() > 0 && q[0].cyc <= cyc) void'(q.pop_front());
      end
      if (pv != 3'b000) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse cyc=%0d got=%b required=none", cyc, pv);
        end else begin
          e = q.pop_front();
          if (e.vec !== pv || e.cyc != cyc) begin
            n_err++;
            $display("FAIL pulse cyc=%0d got=%b required=%b@cyc%0d", cyc, pv, e.vec, e.cyc);
          end
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        n_cmp++;
        n_err++;
        e = q.pop_front();
        $display("FAIL missing_pulse cyc=%0d got=000 required=%b", cyc, e.vec);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset(input string name);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({b_out, b_rise, b_fall, b_hold} !== 4'b0000) begin
      n_err++;
      $display("FAIL %s got=%b required=0000", name, {b_out, b_rise, b_fall, b_hold});
    end
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(3);
    n_cmp++;
    if ({b_out, b_rise, b_fall, b_hold} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_state got=%b required=0000", {b_out, b_rise, b_fall, b_hold});
    end
    reset = 1'b0;
    step(5);

    // clean press through hold
    b_in = 1'b1; step(40);
    // clean release
    b_in = 1'b0; step(15);
    // press, release glitch of 3 cycles before the hold mark
    b_in = 1'b1; step(12);
    b_in = 1'b0; step(3);
    b_in = 1'b1; step(30);
    b_in = 1'b0; step(15);
    // bounce rejection
    for (int i = 0; i < 4; i++) begin
      b_in = ~i[0];
      step(2);
    end
    b_in = 1'b0; step(15);
    // short press released 10 cycles after rise
    b_in = 1'b1; step(S + 2 + 10);
    b_in = 1'b0; step(30);
    // re-press re-arms hold
    b_in = 1'b1; step(40);
    b_in = 1'b0; step(15);
    // reset in WAIT_HIGH with cnt=2, button kept pressed
    b_in = 1'b1; step(5);
    pulse_reset("reset_wait_high");
    step(40);
    // reset while debounced level is high
    pulse_reset("reset_stable_high");
    step(40);
    b_in = 1'b0; step(15);

    for (int i = 0; i < 40; i++) begin
      b_in = 1'($urandom_range(0, 1));
      step($urandom_range(1, 30));
      if ($urandom_range(0, 14) == 0) pulse_reset("reset_random");
    end
    b_in = 1'b0; step(50);

    @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL leftover_expected got=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
